// File: rtl/tc_to_signmag_serial.sv
// Bit-serial two's-complement to sign-magnitude decoder, LSB-first, valid/ready on both sides.
// Optional overflow flag output enabled by defining TC2SM_OVF_FLAG_EN.
module tc_to_signmag_serial #(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic             out_sign,
    output logic [WIDTH-1:0] out_mag,
`ifdef TC2SM_OVF_FLAG_EN
    output logic             ovf,
`endif
    output logic             busy
);
    localparam int CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(WIDTH - 1);
    localparam logic [WIDTH-1:0] MOST_NEG = {1'b1, {(WIDTH-1){1'b0}}};

    typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

    state_t           state, state_nxt;
    logic [WIDTH-1:0] shift_q;
    logic [WIDTH-1:0] mag_q;
    logic [WIDTH-1:0] mag_nxt;
    logic [CNT_W-1:0] cnt_q;
    logic             seen_one;
    logic             sign_q;
    logic             out_sign_q;
    logic [WIDTH-1:0] out_mag_q;
    logic             last_bit;

    // Copy bits up to and including the first one, invert every bit after it.
    function automatic logic mag_bit(input logic b, input logic neg, input logic seen);
        return neg ? (b ^ seen) : b;
    endfunction

    assign last_bit = (cnt_q == LAST_BIT);
    assign mag_nxt  = {mag_bit(shift_q[0], sign_q, seen_one), mag_q[WIDTH-1:1]};

    always_comb begin
        state_nxt = state;
        unique case (state)
            IDLE:    if (in_valid)  state_nxt = SHIFT;
            SHIFT:   if (last_bit)  state_nxt = DONE;
            DONE:    if (out_ready) state_nxt = IDLE;
            default:                state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            shift_q    <= '0;
            mag_q      <= '0;
            cnt_q      <= '0;
            seen_one   <= 1'b0;
            sign_q     <= 1'b0;
            out_sign_q <= 1'b0;
            out_mag_q  <= '0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (in_valid) begin
                        shift_q  <= in_data;
                        sign_q   <= in_data[WIDTH-1];
                        seen_one <= 1'b0;
                        cnt_q    <= '0;
                        mag_q    <= '0;
                    end
                end
                SHIFT: begin
                    shift_q  <= shift_q >> 1;
                    mag_q    <= mag_nxt;
                    seen_one <= seen_one | (sign_q & shift_q[0]);
                    cnt_q    <= cnt_q + 1'b1;
                    // Result registers only change when a new result is ready.
                    if (last_bit) begin
                        out_sign_q <= sign_q;
                        out_mag_q  <= mag_nxt;
                    end
                end
                default: ;
            endcase
        end
    end

`ifdef TC2SM_OVF_FLAG_EN
    logic ovf_q;
    always_ff @(posedge clk) begin
        if (rst) begin
            ovf_q <= 1'b0;
        end else if (state == IDLE && in_valid) begin
            ovf_q <= 1'b0;
        end else if (state == SHIFT && last_bit) begin
            ovf_q <= sign_q && (mag_nxt == MOST_NEG);
        end
    end
    assign ovf = ovf_q;
`endif

    assign in_ready  = (state == IDLE);
    assign out_valid = (state == DONE);
    assign busy      = (state != IDLE);
    assign out_sign  = out_sign_q;
    assign out_mag   = out_mag_q;
endmodule

// File: tb/tb_tc_to_signmag_serial.sv
// Scoreboard bench for tc_to_signmag_serial: driver pushes expected results, monitor pops at each output handshake.
module tb_tc_to_signmag_serial;
    localparam int W = 4;

    logic         clk = 1'b0;
    logic         rst;
    logic         in_valid;
    logic         in_ready;
    logic [W-1:0] in_data;
    logic         out_valid;
    logic         out_ready;
    logic         out_sign;
    logic [W-1:0] out_mag;
    logic         busy;
`ifdef TC2SM_OVF_FLAG_EN
    logic         ovf;
`endif

    typedef struct packed {
        logic         sign;
        logic [W-1:0] mag;
        logic         ovf;
    } exp_t;

    exp_t exp_q[$];
    int   checks = 0;
    int   errors = 0;

    tc_to_signmag_serial #(.WIDTH(W)) dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_sign(out_sign), .out_mag(out_mag),
`ifdef TC2SM_OVF_FLAG_EN
        .ovf(ovf),
`endif
        .busy(busy)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, req);
        end
    endtask

    // Reference: interpret the word as a signed integer and take its absolute value.
    function automatic exp_t model(input logic [W-1:0] w);
        exp_t e;
        int   v;
        v      = w[W-1] ? (int'(w) - (1 << W)) : int'(w);
        e.sign = (v < 0);
        e.mag  = W'((v < 0) ? -v : v);
        e.ovf  = (v == -(1 << (W-1)));
        return e;
    endfunction

    // Monitor: compare whenever the DUT presents a result that is being taken.
    always @(negedge clk) begin
        if (!rst && out_valid && out_ready) begin
            if (exp_q.size() == 0) begin
                chk("unexpected_result", 32'(out_mag), 32'hFFFF);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                chk("out_sign", 32'(out_sign), 32'(e.sign));
                chk("out_mag", 32'(out_mag), 32'(e.mag));
`ifdef TC2SM_OVF_FLAG_EN
                chk("ovf", 32'(ovf), 32'(e.ovf));
`endif
            end
        end
    end

    task automatic wait_ready();
        int n = 0;
        @(negedge clk);
        while (!in_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (!in_ready) chk("in_ready_timeout", 32'(in_ready), 32'd1);
    endtask

    // Send one word; optionally poke in_valid/out_ready during SHIFT, then hold the result.
    task automatic send(input logic [W-1:0] w, input int hold, input bit poke);
        wait_ready();
        in_valid = 1'b1;
        in_data  = w;
        exp_q.push_back(model(w));
        @(posedge clk); #1;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        for (int k = 1; k <= W; k++) begin
            if (poke && k == 2) begin
                in_valid  = 1'b1;
                in_data   = 4'b0011;
                out_ready = 1'b1;
            end
            @(posedge clk); #1;
            in_valid  = 1'b0;
            out_ready = 1'b0;
            chk("latency_out_valid", 32'(out_valid), 32'(k == W));
        end
        for (int h = 0; h < hold; h++) begin
            @(posedge clk); #1;
            chk("hold_out_valid", 32'(out_valid), 32'd1);
            chk("hold_busy", 32'(busy), 32'd1);
        end
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        chk("exit_out_valid", 32'(out_valid), 32'd0);
        chk("exit_in_ready", 32'(in_ready), 32'd1);
    endtask

    initial begin
        rst = 1'b1; in_valid = 1'b0; in_data = '0; out_ready = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_in_ready", 32'(in_ready), 32'd1);
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_out_mag", 32'(out_mag), 32'd0);
        chk("rst_out_sign", 32'(out_sign), 32'd0);
        rst = 1'b0;

        send(4'b0101, 3, 1'b0);
        send(4'b1011, 0, 1'b0);
        send(4'b1111, 1, 1'b0);
        send(4'b1000, 0, 1'b0);
        send(4'b0110, 0, 1'b1);

        for (int i = 0; i < (1 << W); i++) send(W'(i), 0, 1'b0);

        // Reset in the middle of SHIFT must discard the word.
        wait_ready();
        in_valid = 1'b1;
        in_data  = 4'b1010;
        @(posedge clk); #1;
        in_valid = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        chk("midrst_out_valid", 32'(out_valid), 32'd0);
        chk("midrst_in_ready", 32'(in_ready), 32'd1);
        send(4'b0110, 0, 1'b0);

        for (int i = 0; i < 20; i++) send(W'($urandom), int'($urandom_range(0, 3)), 1'(i % 5 == 0));

        repeat (2) @(posedge clk);
        chk("scoreboard_empty", 32'(exp_q.size()), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
